// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: queued request layout,
// grant encoding and accelerator FIFO occupancy states.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_ACC
    } wb_gnt_e;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of core writeback, accelerator result, register-file write and
// issue-tracking signals, plus debug visibility of grant and FIFO state.
interface rf_writeback_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = 32
);
    // Accelerator results use valid/ready: an entry transfers on any rising edge where
    // acc_valid and acc_ready are both high; core writebacks are not flow-controlled and
    // are simply re-presented on the cycle after core_wb_hold is seen high.
    logic                  core_wb_valid;
    logic [REG_ADDR_W-1:0] core_wb_rd;
    logic [DATA_W-1:0]     core_wb_data;
    logic                  core_wb_hold;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [REG_ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0]     acc_data;
    logic                  rf_write_en;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0]     rf_data;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    wb_gnt_e               dbg_gnt;
    fifo_state_e           dbg_fifo_state;
    logic [7:0]            dbg_fifo_count;

    modport master (
        output core_wb_valid, core_wb_rd, core_wb_data,
        output acc_valid, acc_rd, acc_data,
        output issue_valid, issue_rd,
        input  core_wb_hold, acc_ready,
        input  rf_write_en, rf_rd, rf_data, pending_mask,
        input  dbg_gnt, dbg_fifo_state, dbg_fifo_count
    );

    modport slave (
        input  core_wb_valid, core_wb_rd, core_wb_data,
        input  acc_valid, acc_rd, acc_data,
        input  issue_valid, issue_rd,
        output core_wb_hold, acc_ready,
        output rf_write_en, rf_rd, rf_data, pending_mask,
        output dbg_gnt, dbg_fifo_state, dbg_fifo_count
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of queued accelerator writebacks; the head is read
// combinationally and push with pop is accepted even when full.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  wb_req_t          push_data_i,
    input  logic             pop_i,
    output wb_req_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fifo_state_e      state_o
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        state_o = FIFO_PARTIAL;
        if (empty_o) state_o = FIFO_EMPTY;
        else if (full_o) state_o = FIFO_FULL;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Sole writer of the register file: core writebacks win, queued accelerator results
// drain on idle cycles or when starved. Optional pending-register tracking: WB_SCOREBOARD_EN.
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    rf_writeback_arbiter_if.slave  bus
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_gnt_e               gnt;
    wb_req_t               acc_req, fifo_head;
    logic                  fifo_full, fifo_empty, acc_ready_w;
    logic [CNT_W-1:0]      fifo_count;
    fifo_state_e           fifo_state;
    logic                  we_q, we_d, hold_q, hold_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;

    assign acc_req     = {bus.acc_rd, bus.acc_data};
    assign acc_ready_w = reset && !fifo_full;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.acc_valid && acc_ready_w),
        .push_data_i (acc_req),
        .pop_i       (gnt == GNT_ACC),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .state_o     (fifo_state)
    );

    // A core request to x0 never wins, so an idle FIFO head can use that slot.
    always_comb begin
        gnt = GNT_NONE;
        if (hold_q) begin
            if (!fifo_empty) gnt = GNT_ACC;
        end else if (bus.core_wb_valid && bus.core_wb_rd != '0) begin
            gnt = GNT_CORE;
        end else if (!fifo_empty) begin
            gnt = GNT_ACC;
        end
    end

    always_comb begin
        we_d     = 1'b0;
        rd_d     = '0;
        data_d   = '0;
        starve_d = '0;
        hold_d   = 1'b0;
        case (gnt)
            GNT_CORE: begin
                we_d   = 1'b1;
                rd_d   = bus.core_wb_rd;
                data_d = bus.core_wb_data;
            end
            GNT_ACC: begin
                we_d   = (fifo_head.rd != '0);
                rd_d   = fifo_head.rd;
                data_d = fifo_head.data;
            end
            default: begin
                if (bus.core_wb_valid && !hold_q) begin
                    rd_d   = bus.core_wb_rd;
                    data_d = bus.core_wb_data;
                end
            end
        endcase
        // Reaching the limit forces exactly one drain cycle on the next clock.
        if (gnt == GNT_CORE && !fifo_empty) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) hold_d = 1'b1;
            else starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.rf_write_en    = we_q;
    assign bus.rf_rd          = rd_q;
    assign bus.rf_data        = data_q;
    assign bus.core_wb_hold   = hold_q;
    assign bus.acc_ready      = acc_ready_w;
    assign bus.dbg_gnt        = gnt;
    assign bus.dbg_fifo_state = fifo_state;
    assign bus.dbg_fifo_count = 8'(fifo_count);

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q, pend_d;

    // A new issue to the same register as a retiring entry keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (gnt == GNT_ACC) pend_d[fifo_head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) pend_d[bus.issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign bus.pending_mask = pend_q;
`else
    logic unused_issue;
    assign unused_issue     = ^{bus.issue_valid, bus.issue_rd};
    assign bus.pending_mask = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: core priority, x0 handling, FIFO fill,
// starvation drain, mid-stream reset and pending-register tracking.
module tb_rf_writeback_arbiter;
    import rf_wb_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] exp_mask12;

    rf_writeback_arbiter_if #(.DATA_W(32)) bus ();

    rf_writeback_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic idle();
        bus.core_wb_valid = 1'b0;
        bus.core_wb_rd    = '0;
        bus.core_wb_data  = '0;
        bus.acc_valid     = 1'b0;
        bus.acc_rd        = '0;
        bus.acc_data      = '0;
        bus.issue_valid   = 1'b0;
        bus.issue_rd      = '0;
    endtask

    task automatic drive_core(input logic [4:0] rd, input logic [31:0] data);
        bus.core_wb_valid = 1'b1;
        bus.core_wb_rd    = rd;
        bus.core_wb_data  = data;
    endtask

    task automatic drive_acc(input logic [4:0] rd, input logic [31:0] data);
        bus.acc_valid = 1'b1;
        bus.acc_rd    = rd;
        bus.acc_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every register-file write must match the next expected entry
    always @(negedge clk) begin
        if (reset && bus.rf_write_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(bus.rf_write_en), 64'd0);
            end else begin
                check("wr_order", 64'({bus.rf_rd, bus.rf_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
`ifdef WB_SCOREBOARD_EN
        exp_mask12 = 32'h0000_1000;
`else
        exp_mask12 = 32'h0;
`endif
        reset = 1'b0;
        idle();
        #2;
        check("rst_we", 64'(bus.rf_write_en), 64'd0);
        check("rst_rd", 64'(bus.rf_rd), 64'd0);
        check("rst_data", 64'(bus.rf_data), 64'd0);
        check("rst_ready", 64'(bus.acc_ready), 64'd0);
        check("rst_hold", 64'(bus.core_wb_hold), 64'd0);
        check("rst_mask", 64'(bus.pending_mask), 64'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("ready_after_rst", 64'(bus.acc_ready), 64'd1);
        check("count_after_rst", 64'(bus.dbg_fifo_count), 64'd0);

        // core only
        drive_core(5'd5, 32'h0111_4444);
        exp_q.push_back({5'd5, 32'h0111_4444});
        step();
        check("core_we", 64'(bus.rf_write_en), 64'd1);
        check("core_rd", 64'(bus.rf_rd), 64'd5);
        check("core_data", 64'(bus.rf_data), 64'h0111_4444);
        idle();
        step();
        check("idle_we", 64'(bus.rf_write_en), 64'd0);

        // core x0 lets the FIFO head through
        drive_acc(5'd7, 32'hA5A5_A5A5);
        step();
        check("x0_count_before", 64'(bus.dbg_fifo_count), 64'd1);
        idle();
        drive_core(5'd0, 32'h5555_0000);
        exp_q.push_back({5'd7, 32'hA5A5_A5A5});
        step();
        check("x0_rd", 64'(bus.rf_rd), 64'd7);
        check("x0_data", 64'(bus.rf_data), 64'hA5A5_A5A5);
        check("x0_state", 64'(bus.dbg_fifo_state), 64'(FIFO_EMPTY));
        idle();
        step();

        // fill with core busy
        for (int i = 0; i < 4; i++) begin
            drive_core(5'(i + 1), 32'(i + 32'h100));
            drive_acc(5'(i + 10), 32'(i + 32'hA00));
            exp_q.push_back({5'(i + 1), 32'(i + 32'h100)});
            step();
            check("fill_count", 64'(bus.dbg_fifo_count), 64'(i + 1));
        end
        check("full_ready", 64'(bus.acc_ready), 64'd0);
        check("full_state", 64'(bus.dbg_fifo_state), 64'(FIFO_FULL));
        bus.core_wb_valid = 1'b0;
        drive_acc(5'd14, 32'h0000_0A04);
        exp_q.push_back({5'd10, 32'h0000_0A00});
        step();
        check("full_push_refused", 64'(bus.dbg_fifo_count), 64'd3);
        exp_q.push_back({5'd11, 32'h0000_0A01});
        step();
        check("push_pop_count", 64'(bus.dbg_fifo_count), 64'd3);
        idle();
        exp_q.push_back({5'd12, 32'h0000_0A02});
        exp_q.push_back({5'd13, 32'h0000_0A03});
        exp_q.push_back({5'd14, 32'h0000_0A04});
        for (int i = 0; i < 3; i++) step();
        check("drain_count", 64'(bus.dbg_fifo_count), 64'd0);
        check("drain_rd", 64'(bus.rf_rd), 64'd14);
        step();

        // accelerator entry to x0 completes without a write
        drive_acc(5'd0, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        check("acc_x0_we", 64'(bus.rf_write_en), 64'd0);
        check("acc_x0_data", 64'(bus.rf_data), 64'hDEAD_BEEF);
        check("acc_x0_count", 64'(bus.dbg_fifo_count), 64'd0);

        // same rd on core and head: core wins, head stays
        drive_acc(5'd6, 32'h0000_00AA);
        step();
        idle();
        drive_core(5'd6, 32'h0000_00BB);
        exp_q.push_back({5'd6, 32'h0000_00BB});
        step();
        check("same_rd_data", 64'(bus.rf_data), 64'h0000_00BB);
        check("same_rd_count", 64'(bus.dbg_fifo_count), 64'd1);
        idle();
        exp_q.push_back({5'd6, 32'h0000_00AA});
        step();
        check("same_rd_drain", 64'(bus.rf_data), 64'h0000_00AA);
        step();

        // starvation guard
        drive_acc(5'd9, 32'h0000_1234);
        step();
        idle();
        for (int i = 1; i <= 8; i++) begin
            drive_core(5'd3, 32'(i));
            exp_q.push_back({5'd3, 32'(i)});
            step();
            check("starve_hold", 64'(bus.core_wb_hold), 64'(i == 8));
        end
        drive_core(5'd3, 32'd9);
        exp_q.push_back({5'd9, 32'h0000_1234});
        step();
        check("starve_drain_rd", 64'(bus.rf_rd), 64'd9);
        check("starve_drain_data", 64'(bus.rf_data), 64'h0000_1234);
        check("starve_hold_clear", 64'(bus.core_wb_hold), 64'd0);
        exp_q.push_back({5'd3, 32'd9});
        step();
        check("starve_retry_rd", 64'(bus.rf_rd), 64'd3);
        check("starve_retry_data", 64'(bus.rf_data), 64'd9);
        idle();
        step();

        // reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive_core(5'd20, 32'(i + 1));
            drive_acc(5'(i + 21), 32'(i + 32'hB00));
            exp_q.push_back({5'd20, 32'(i + 1)});
            step();
        end
        check("prerst_count", 64'(bus.dbg_fifo_count), 64'd3);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_we", 64'(bus.rf_write_en), 64'd0);
        check("midrst_ready", 64'(bus.acc_ready), 64'd0);
        check("midrst_count", 64'(bus.dbg_fifo_count), 64'd0);
        idle();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("postrst_we", 64'(bus.rf_write_en), 64'd0);

        // pending-register tracking
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        step();
        check("mask_set", 64'(bus.pending_mask), 64'(exp_mask12));
        idle();
        drive_acc(5'd12, 32'hC0FF_EE12);
        step();
        check("mask_queued", 64'(bus.pending_mask), 64'(exp_mask12));
        idle();
        exp_q.push_back({5'd12, 32'hC0FF_EE12});
        step();
        check("mask_clear", 64'(bus.pending_mask), 64'd0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        step();
        idle();
        step();
        check("mask_x0", 64'(bus.pending_mask), 64'd0);

        step();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
